piso_bit_serializer: RTL and testbench
======================================

// Module: piso_bit_serializer
// PURPOSE
//  Parallel-in/serial-out stage feeding the 101 Mealy sequence detector's
//  single-bit "in" port. Accepts a WIDTH-bit word on a valid/ready handshake.
//  Emits the word one bit per clk on "out", with "out_valid" and a last-bit
//  "frame_done" strobe. Consecutive words stream with no idle gap.
// PARAMETERS
//  WIDTH      8   bits per word; legal range >= 2
//  MSB_FIRST  1   1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
//  IDLE_BIT   0   value driven on out whenever out_valid=0
// PORTS
//  clk         in   1             single clock; all logic on posedge
//  reset       in   1             synchronous, active-high
//  load_data   in   WIDTH         parallel word to send
//  load_valid  in   1             load_data is valid
//  load_ready  out  1             serializer can take a word this cycle
//  out         out  1             serial bit; connects to detector "in"
//  out_valid   out  1             out carries a real data bit
//  frame_done  out  1             high while the last bit of a word is on out
//  bit_idx     out  $clog2(WIDTH) index of the current bit within the frame (0 = first)
// BEHAVIOUR
//  - The single clock is clk. reset is synchronous and active-high. While reset=1 on an
//    edge, the block enters IDLE with out=IDLE_BIT, out_valid=0, frame_done=0, bit_idx=0
//    and the shift register cleared. load_ready=0 in any cycle where reset=1.
//  - out, out_valid, frame_done and bit_idx are registered.
//    load_ready is combinational: (state==IDLE) || (state==SHIFT && bit_idx==WIDTH-1),
//    forced to 0 while reset=1.
//  - Accept occurs on a posedge where load_valid && load_ready. At that edge the word is
//    captured, and out takes the first bit (load_data[WIDTH-1] if MSB_FIRST, else
//    load_data[0]). Also at that edge: out_valid=1, bit_idx=0, state=SHIFT.
//    Latency is one cycle from accept edge to first bit.
//  - FSM IDLE: out_valid=0 and out=IDLE_BIT. An accept moves to SHIFT; otherwise stay.
//  - FSM SHIFT: each edge advances to the next bit and increments bit_idx.
//    frame_done=1 exactly when bit_idx==WIDTH-1 (registered with that bit).
//  - End of frame, at the edge following bit WIDTH-1:
//      accept present -> new word's first bit, bit_idx=0, stay SHIFT (zero-gap streaming);
//      no accept      -> IDLE, out_valid=0, out=IDLE_BIT, frame_done=0.
//  - load_valid while load_ready=0 (mid-frame) is ignored. The word is not captured, and
//    the upstream must hold it until ready.
//  - Reset asserted mid-frame aborts the frame. Remaining bits are discarded and no
//    frame_done is issued. The first edge after reset deasserts may accept a new word.
//  - bit_idx saturates at no value other than WIDTH-1. It never wraps past WIDTH-1
//    within a frame.
// TESTING
//  1 Reset: hold reset 2 cycles with load_valid=1 -> out_valid=0, out=0, load_ready=0,
//    nothing accepted.
//  2 Single word 8'b1010_0000, MSB_FIRST=1, one-cycle valid -> out=1,0,1,0,0,0,0,0 on
//    the 8 cycles after accept. frame_done only on the 8th cycle, then out_valid=0.
//  3 Back-to-back: 8'hA5 then 8'h3C, load_valid held high -> 16 contiguous valid bits
//    10100101_00111100. Second accept happens in the frame_done cycle of the first word.
//  4 Mid-frame load_valid=1 with 8'hFF at bit_idx=3 of 8'h00 -> out stays 0 for the
//    frame. 8'hFF is accepted only in the frame_done cycle.
//  5 Reset at bit_idx=4 of 8'hF0 -> next edge out_valid=0, frame_done never pulses,
//    and the next word sends cleanly from bit 0.
//  6 MSB_FIRST=0, word 8'b0000_0101 into the detector -> serial 1,0,1,0,0,0,0,0.
//    Detector y=1 exactly once, on the third bit.

Source files
------------

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out stage: takes a WIDTH-bit word on a valid/ready handshake
// and emits it one bit per clock, streaming back-to-back words with no idle gap.
module piso_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         load_data,
    input  logic                     load_valid,
    output logic                     load_ready,
    output logic                     out,
    output logic                     out_valid,
    output logic                     frame_done,
    output logic [$clog2(WIDTH)-1:0] bit_idx
);

    localparam int                IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic             out_next;
    logic             out_valid_next;
    logic             frame_done_next;
    logic [IDX_W-1:0] bit_idx_next;
    logic             at_last;
    logic             accept;

    // The last-bit cycle doubles as the accept window for the next word.
    assign at_last    = (state == SHIFT) && (bit_idx == LAST_IDX);
    assign load_ready = !reset && ((state == IDLE) || at_last);
    assign accept     = load_valid && load_ready;

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    always_comb begin
        state_next      = state;
        shreg_next      = shreg;
        out_next        = IDLE_BIT;
        out_valid_next  = 1'b0;
        frame_done_next = 1'b0;
        bit_idx_next    = '0;

        if (accept) begin
            // First bit goes straight to out; the register keeps the remaining bits.
            state_next     = SHIFT;
            shreg_next     = advance(load_data);
            out_next       = head(load_data);
            out_valid_next = 1'b1;
        end else begin
            case (state)
                SHIFT: begin
                    if (at_last) begin
                        state_next = IDLE;
                        shreg_next = '0;
                    end else begin
                        shreg_next      = advance(shreg);
                        out_next        = head(shreg);
                        out_valid_next  = 1'b1;
                        bit_idx_next    = bit_idx + 1'b1;
                        frame_done_next = ((bit_idx + 1'b1) == LAST_IDX);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: non-blocking assignments here so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            out        <= IDLE_BIT;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            bit_idx    <= '0;
        end else begin
            state      <= state_next;
            shreg      <= shreg_next;
            out        <= out_next;
            out_valid  <= out_valid_next;
            frame_done <= frame_done_next;
            bit_idx    <= bit_idx_next;
        end
    end

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Directed bench for piso_bit_serializer: an MSB-first and an LSB-first instance,
// with a behavioural 101 Mealy detector watching the LSB-first stream.
module tb_piso_bit_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ld_m, ld_l;
    logic       lv_m, lv_l;
    logic       rdy_m, out_m, ov_m, fd_m;
    logic       rdy_l, out_l, ov_l, fd_l;
    logic [2:0] idx_m, idx_l;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
        .clk        (clk),
        .reset      (reset),
        .load_data  (ld_m),
        .load_valid (lv_m),
        .load_ready (rdy_m),
        .out        (out_m),
        .out_valid  (ov_m),
        .frame_done (fd_m),
        .bit_idx    (idx_m)
    );

    piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk        (clk),
        .reset      (reset),
        .load_data  (ld_l),
        .load_valid (lv_l),
        .load_ready (rdy_l),
        .out        (out_l),
        .out_valid  (ov_l),
        .frame_done (fd_l),
        .bit_idx    (idx_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs are registered: sample 1 time unit after the active edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_m(input string tag, input logic b, input int idx);
        check({tag, "_out"}, out_m, b);
        check({tag, "_valid"}, ov_m, 1'b1);
        check({tag, "_idx"}, idx_m, idx);
        check({tag, "_done"}, fd_m, idx == 7);
    endtask

    task automatic expect_idle_m(input string tag);
        check({tag, "_idle_valid"}, ov_m, 1'b0);
        check({tag, "_idle_out"}, out_m, 1'b0);
        check({tag, "_idle_done"}, fd_m, 1'b0);
    endtask

    logic [7:0]  word8;
    logic [15:0] stream;
    int          det_state;
    int          y_count;
    int          y_pos;

    initial begin
        // 1: reset held two cycles with load_valid asserted
        reset = 1'b1;
        ld_m  = 8'hAA;
        ld_l  = 8'h55;
        lv_m  = 1'b1;
        lv_l  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick;
            expect_idle_m("t1");
            check("t1_idx", idx_m, 0);
            check("t1_ready_m", rdy_m, 1'b0);
            check("t1_ready_l", rdy_l, 1'b0);
            check("t1_valid_l", ov_l, 1'b0);
        end
        reset = 1'b0;
        lv_m  = 1'b0;
        lv_l  = 1'b0;
        #1;
        check("t1_ready_after", rdy_m, 1'b1);
        tick;
        expect_idle_m("t1_post");

        // 2: single word, one-cycle valid
        word8 = 8'hA0;
        ld_m  = word8;
        lv_m  = 1'b1;
        tick;
        lv_m = 1'b0;
        for (int i = 0; i < 8; i++) begin
            expect_m("t2", word8[7-i], i);
            check("t2_ready", rdy_m, i == 7);
            tick;
        end
        expect_idle_m("t2_end");

        // 3: back-to-back words with load_valid held high
        stream = 16'hA53C;
        ld_m   = 8'hA5;
        lv_m   = 1'b1;
        tick;
        ld_m = 8'h3C;
        for (int j = 0; j < 16; j++) begin
            expect_m("t3", stream[15-j], j % 8);
            check("t3_ready", rdy_m, (j % 8) == 7);
            if (j == 15) lv_m = 1'b0;
            tick;
        end
        expect_idle_m("t3_end");

        // 4: mid-frame load_valid is ignored until the frame_done cycle
        ld_m = 8'h00;
        lv_m = 1'b1;
        tick;
        lv_m = 1'b0;
        for (int i = 0; i < 8; i++) begin
            expect_m("t4_zero", 1'b0, i);
            check("t4_ready", rdy_m, i == 7);
            if (i == 3) begin
                ld_m = 8'hFF;
                lv_m = 1'b1;
            end
            tick;
        end
        for (int k = 0; k < 8; k++) begin
            expect_m("t4_ff", 1'b1, k);
            if (k == 0) lv_m = 1'b0;
            tick;
        end
        expect_idle_m("t4_end");

        // 5: reset at bit_idx 4 aborts the frame
        word8 = 8'hF0;
        ld_m  = word8;
        lv_m  = 1'b1;
        tick;
        lv_m = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expect_m("t5", word8[7-i], i);
            if (i < 4) tick;
        end
        reset = 1'b1;
        #1;
        check("t5_ready_in_reset", rdy_m, 1'b0);
        tick;
        expect_idle_m("t5_abort");
        check("t5_abort_idx", idx_m, 0);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick;
            expect_idle_m("t5_quiet");
        end
        word8 = 8'h81;
        ld_m  = word8;
        lv_m  = 1'b1;
        #1;
        check("t5_ready_new", rdy_m, 1'b1);
        tick;
        lv_m = 1'b0;
        for (int i = 0; i < 8; i++) begin
            expect_m("t5_new", word8[7-i], i);
            tick;
        end
        expect_idle_m("t5_end");

        // 6: LSB-first word 0000_0101 into a 101 Mealy detector model
        word8     = 8'h05;
        ld_l      = word8;
        lv_l      = 1'b1;
        det_state = 0;
        y_count   = 0;
        y_pos     = -1;
        tick;
        lv_l = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("t6_out", out_l, word8[i]);
            check("t6_valid", ov_l, 1'b1);
            check("t6_idx", idx_l, i);
            check("t6_done", fd_l, i == 7);
            case (det_state)
                0: det_state = out_l ? 1 : 0;
                1: det_state = out_l ? 1 : 2;
                default: begin
                    if (out_l) begin
                        y_count++;
                        y_pos     = i;
                        det_state = 1;
                    end else begin
                        det_state = 0;
                    end
                end
            endcase
            tick;
        end
        check("t6_y_count", y_count, 1);
        check("t6_y_pos", y_pos, 2);
        check("t6_idle_valid", ov_l, 1'b0);
        check("t6_idle_out", out_l, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
